regbank_write_arbiter: RTL and testbench

- Sequences the single write port of the 8088 register bank (en_write, reg_write, write_data, size, select_high_low) among three requesters.
- Requesters: execution unit (EU), bus interface unit (BIU: IP/segment updates), string unit (STR: SI/DI/CX auto-update).
- Per-requester req/ack handshake, registered write-port outputs, and an EU lock so multi-write instructions (XCHG, POP reg pairs) complete back-to-back without interleaving.

---
 rtl/regbank_write_arbiter_if.sv | 69 ++++++
 rtl/regbank_write_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_regbank_write_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// regbank_write_arbiter_if
//   Bundles the three requester handshakes (EU, BIU, STR) and the single
//   register-bank write port driven by regbank_write_arbiter.
//
//   Requester side (driven by requesters, read by arbiter):
//     <r>_req, <r>_reg, <r>_data, <r>_size, <r>_hl   for r in {eu, biu, str}
//     eu_lock                                        EU exclusive-access hint
//   Arbiter side (driven by arbiter):
//     eu_ack, biu_ack, str_ack                       one-cycle write-done pulses
//     en_write, reg_write, write_data, size,
//     select_high_low                                bank write port
//     busy                                           arbiter not idle
//
//   Modports: master = requester/bank view, slave = arbiter view.
// ----------------------------------------------------------------------------
interface regbank_write_arbiter_if #(
    parameter int unsigned REG_IDX_W = 4,
    parameter int unsigned DATA_W    = 16
);
    logic                 eu_req;
    logic                 biu_req;
    logic                 str_req;
    logic [REG_IDX_W-1:0] eu_reg;
    logic [REG_IDX_W-1:0] biu_reg;
    logic [REG_IDX_W-1:0] str_reg;
    logic [DATA_W-1:0]    eu_data;
    logic [DATA_W-1:0]    biu_data;
    logic [DATA_W-1:0]    str_data;
    logic                 eu_size;
    logic                 biu_size;
    logic                 str_size;
    logic                 eu_hl;
    logic                 biu_hl;
    logic                 str_hl;
    logic                 eu_lock;

    logic                 eu_ack;
    logic                 biu_ack;
    logic                 str_ack;
    logic                 en_write;
    logic [REG_IDX_W-1:0] reg_write;
    logic [DATA_W-1:0]    write_data;
    logic                 size;
    logic                 select_high_low;
    logic                 busy;

    modport master (
        output eu_req, biu_req, str_req,
        output eu_reg, biu_reg, str_reg,
        output eu_data, biu_data, str_data,
        output eu_size, biu_size, str_size,
        output eu_hl, biu_hl, str_hl,
        output eu_lock,
        input  eu_ack, biu_ack, str_ack,
        input  en_write, reg_write, write_data, size, select_high_low, busy
    );

    modport slave (
        input  eu_req, biu_req, str_req,
        input  eu_reg, biu_reg, str_reg,
        input  eu_data, biu_data, str_data,
        input  eu_size, biu_size, str_size,
        input  eu_hl, biu_hl, str_hl,
        input  eu_lock,
        output eu_ack, biu_ack, str_ack,
        output en_write, reg_write, write_data, size, select_high_low, busy
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// ----------------------------------------------------------------------------
// regbank_write_arbiter
//   Sequences the single write port of the 8088 register bank among the
//   execution unit (EU), bus interface unit (BIU) and string unit (STR).
//   A grant is latched in IDLE and performed in the following WRITE cycle,
//   giving one write every two cycles. The EU may hold eu_lock to keep the
//   port across up to LOCK_MAX consecutive writes; after a full-length lock
//   run the EU sits out one arbitration so other requesters are not starved.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    regbank_write_arbiter_if.slave: requester handshakes + write port
//
// Configuration:
//   ARB_ROUND_ROBIN_EN  defined: round-robin EU->BIU->STR arbitration in IDLE.
//                       undefined: fixed priority EU > BIU > STR.
// ----------------------------------------------------------------------------
module regbank_write_arbiter #(
    parameter int unsigned REG_IDX_W = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LOCK_MAX  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    regbank_write_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StLock
    } state_e;

    state_e               r_state,      w_state_d;
    logic [3:0]           r_lock_cnt,   w_lock_cnt_d;
    logic                 r_skip_eu,    w_skip_eu_d;
    logic                 r_win_eu,     w_win_eu_d;
    logic                 r_en_write,   w_en_write_d;
    logic                 r_eu_ack,     w_eu_ack_d;
    logic                 r_biu_ack,    w_biu_ack_d;
    logic                 r_str_ack,    w_str_ack_d;
    logic [REG_IDX_W-1:0] r_reg,        w_reg_d;
    logic [DATA_W-1:0]    r_data,       w_data_d;
    logic                 r_size,       w_size_d;
    logic                 r_hl,         w_hl_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0]           r_rr,         w_rr_d;     // 0: EU, 1: BIU, 2: STR first
`endif

    logic       w_any_req;
    logic [2:0] w_req;      // {STR, BIU, EU} eligible this arbitration
    logic [2:0] w_gnt;      // one-hot winner

    assign w_any_req = bus.eu_req | bus.biu_req | bus.str_req;
    assign w_req     = {bus.str_req, bus.biu_req, bus.eu_req & ~r_skip_eu};

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        w_gnt = 3'b000;
        unique case (r_rr)
            2'd0: begin
                if      (w_req[0]) w_gnt[0] = 1'b1;
                else if (w_req[1]) w_gnt[1] = 1'b1;
                else if (w_req[2]) w_gnt[2] = 1'b1;
            end
            2'd1: begin
                if      (w_req[1]) w_gnt[1] = 1'b1;
                else if (w_req[2]) w_gnt[2] = 1'b1;
                else if (w_req[0]) w_gnt[0] = 1'b1;
            end
            default: begin
                if      (w_req[2]) w_gnt[2] = 1'b1;
                else if (w_req[0]) w_gnt[0] = 1'b1;
                else if (w_req[1]) w_gnt[1] = 1'b1;
            end
        endcase
    end
`else
    assign w_gnt[0] = w_req[0];
    assign w_gnt[1] = w_req[1] & ~w_req[0];
    assign w_gnt[2] = w_req[2] & ~(|w_req[1:0]);
`endif

    always_comb begin
        w_state_d    = r_state;
        w_lock_cnt_d = r_lock_cnt;
        w_skip_eu_d  = r_skip_eu;
        w_win_eu_d   = r_win_eu;
        w_en_write_d = 1'b0;
        w_eu_ack_d   = 1'b0;
        w_biu_ack_d  = 1'b0;
        w_str_ack_d  = 1'b0;
        w_reg_d      = '0;
        w_data_d     = '0;
        w_size_d     = 1'b0;
        w_hl_d       = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        w_rr_d       = r_rr;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    // Any arbitration consumes the skip, even if EU was the only requester.
                    w_skip_eu_d = 1'b0;
                    if (|w_gnt) begin
                        w_state_d    = StWrite;
                        w_en_write_d = 1'b1;
                        w_win_eu_d   = w_gnt[0];
                        unique case (1'b1)
                            w_gnt[0]: begin
                                w_eu_ack_d = 1'b1;
                                w_reg_d    = bus.eu_reg;
                                w_data_d   = bus.eu_data;
                                w_size_d   = bus.eu_size;
                                w_hl_d     = bus.eu_hl;
                            end
                            w_gnt[1]: begin
                                w_biu_ack_d = 1'b1;
                                w_reg_d     = bus.biu_reg;
                                w_data_d    = bus.biu_data;
                                w_size_d    = bus.biu_size;
                                w_hl_d      = bus.biu_hl;
                            end
                            w_gnt[2]: begin
                                w_str_ack_d = 1'b1;
                                w_reg_d     = bus.str_reg;
                                w_data_d    = bus.str_data;
                                w_size_d    = bus.str_size;
                                w_hl_d      = bus.str_hl;
                            end
                            default: ;
                        endcase
`ifdef ARB_ROUND_ROBIN_EN
                        // Only IDLE grants move the pointer; lock continuations do not.
                        w_rr_d = w_gnt[0] ? 2'd1 : (w_gnt[1] ? 2'd2 : 2'd0);
`endif
                    end
                end
            end
            StWrite: begin
                if (r_win_eu && bus.eu_lock) begin
                    if (32'(r_lock_cnt) + 32'd1 < LOCK_MAX) begin
                        w_state_d    = StLock;
                        w_lock_cnt_d = r_lock_cnt + 4'd1;
                    end else begin
                        w_state_d    = StIdle;
                        w_lock_cnt_d = 4'd0;
                        w_skip_eu_d  = 1'b1;
                    end
                end else begin
                    w_state_d    = StIdle;
                    w_lock_cnt_d = 4'd0;
                end
            end
            StLock: begin
                // Continuation requires both req and lock; otherwise the lock is released.
                if (bus.eu_req && bus.eu_lock) begin
                    w_state_d    = StWrite;
                    w_en_write_d = 1'b1;
                    w_win_eu_d   = 1'b1;
                    w_eu_ack_d   = 1'b1;
                    w_reg_d      = bus.eu_reg;
                    w_data_d     = bus.eu_data;
                    w_size_d     = bus.eu_size;
                    w_hl_d       = bus.eu_hl;
                end else begin
                    w_state_d    = StIdle;
                    w_lock_cnt_d = 4'd0;
                end
            end
            default: begin
                w_state_d    = StIdle;
                w_lock_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_lock_cnt <= 4'd0;
            r_skip_eu  <= 1'b0;
            r_win_eu   <= 1'b0;
            r_en_write <= 1'b0;
            r_eu_ack   <= 1'b0;
            r_biu_ack  <= 1'b0;
            r_str_ack  <= 1'b0;
            r_reg      <= '0;
            r_data     <= '0;
            r_size     <= 1'b0;
            r_hl       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr       <= 2'd0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_lock_cnt <= w_lock_cnt_d;
            r_skip_eu  <= w_skip_eu_d;
            r_win_eu   <= w_win_eu_d;
            r_en_write <= w_en_write_d;
            r_eu_ack   <= w_eu_ack_d;
            r_biu_ack  <= w_biu_ack_d;
            r_str_ack  <= w_str_ack_d;
            r_reg      <= w_reg_d;
            r_data     <= w_data_d;
            r_size     <= w_size_d;
            r_hl       <= w_hl_d;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr       <= w_rr_d;
`endif
        end
    end

    assign bus.en_write        = r_en_write;
    assign bus.reg_write       = r_reg;
    assign bus.write_data      = r_data;
    assign bus.size            = r_size;
    assign bus.select_high_low = r_hl;
    assign bus.eu_ack          = r_eu_ack;
    assign bus.biu_ack         = r_biu_ack;
    assign bus.str_ack         = r_str_ack;
    assign bus.busy            = (r_state != StIdle);

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regbank_write_arbiter
//   Self-checking bench for regbank_write_arbiter. A grant-level reference
//   model (rotating search over requesters, lock-run counter, skip flag)
//   predicts the bank write port, acks and busy after every clock edge.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_regbank_write_arbiter;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned LOCK_MAX  = 4;

    typedef logic [26:0] vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regbank_write_arbiter_if #(.REG_IDX_W(REG_IDX_W), .DATA_W(DATA_W)) bus ();

    regbank_write_arbiter #(
        .REG_IDX_W (REG_IDX_W),
        .DATA_W    (DATA_W),
        .LOCK_MAX  (LOCK_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Requester stimulus, index 0: EU, 1: BIU, 2: STR
    logic        t_req  [3];
    logic [3:0]  t_reg  [3];
    logic [15:0] t_data [3];
    logic        t_size [3];
    logic        t_hl   [3];
    logic        t_lock;

    // Reference model
    bit          m_in_write;   // the edge just taken latched a grant
    bit          m_locked;
    bit          m_skip;
    int          m_lock_n;
    int          m_rr;
    int          m_win;
    logic        e_en;
    logic [3:0]  e_reg;
    logic [15:0] e_data;
    logic        e_size;
    logic        e_hl;
    logic [2:0]  e_ack;        // {STR, BIU, EU}
    logic        e_busy;

    task automatic drive();
        bus.eu_req   = t_req[0];  bus.biu_req  = t_req[1];  bus.str_req  = t_req[2];
        bus.eu_reg   = t_reg[0];  bus.biu_reg  = t_reg[1];  bus.str_reg  = t_reg[2];
        bus.eu_data  = t_data[0]; bus.biu_data = t_data[1]; bus.str_data = t_data[2];
        bus.eu_size  = t_size[0]; bus.biu_size = t_size[1]; bus.str_size = t_size[2];
        bus.eu_hl    = t_hl[0];   bus.biu_hl   = t_hl[1];   bus.str_hl   = t_hl[2];
        bus.eu_lock  = t_lock;
    endtask

    function automatic void clear_outputs();
        e_en = 1'b0; e_reg = '0; e_data = '0; e_size = 1'b0; e_hl = 1'b0; e_ack = '0;
    endfunction

    function automatic void model_reset();
        m_in_write = 0; m_locked = 0; m_skip = 0; m_lock_n = 0; m_rr = 0; m_win = 0;
        clear_outputs();
        e_busy = 1'b0;
    endfunction

    function automatic void grant(int w);
        m_in_write = 1;
        m_win      = w;
        e_en       = 1'b1;
        e_ack[w]   = 1'b1;
        e_reg      = t_reg[w];
        e_data     = t_data[w];
        e_size     = t_size[w];
        e_hl       = t_hl[w];
    endfunction

    // One clock edge of the arbiter, described by grant rules.
    function automatic void model_step();
        int w;
        clear_outputs();
        if (m_in_write) begin
            m_in_write = 0;
            if (m_win == 0 && t_lock) begin
                if (m_lock_n + 1 < int'(LOCK_MAX)) begin
                    m_locked = 1;
                    m_lock_n++;
                end else begin
                    m_lock_n = 0;
                    m_skip   = 1;
                end
            end else begin
                m_lock_n = 0;
            end
        end else if (m_locked) begin
            m_locked = 0;
            if (t_req[0] && t_lock) grant(0);
            else m_lock_n = 0;
        end else if (t_req[0] || t_req[1] || t_req[2]) begin
            w = -1;
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (m_rr + k) % 3;
                if (w < 0 && t_req[c] && !(c == 0 && m_skip)) w = c;
            end
            m_skip = 0;
            if (w >= 0) begin
                grant(w);
`ifdef ARB_ROUND_ROBIN_EN
                m_rr = (w + 1) % 3;
`endif
            end
        end
        e_busy = m_in_write || m_locked;
    endfunction

    function automatic vec_t obs();
        return {bus.en_write, bus.reg_write, bus.write_data, bus.size, bus.select_high_low,
                bus.str_ack, bus.biu_ack, bus.eu_ack, bus.busy};
    endfunction

    function automatic vec_t expv();
        return {e_en, e_reg, e_data, e_size, e_hl, e_ack, e_busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 3; i++) begin
            t_req[i] = 1'b0; t_reg[i] = '0; t_data[i] = '0; t_size[i] = 1'b0; t_hl[i] = 1'b0;
        end
        t_lock = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (obs() !== vec_t'(0)) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", obs());
        end
        model_reset();
        tick();
        reset = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL reset_idle c%0d got %h want %h", c, obs(), expv());
            end
        end
    endtask

    task automatic test_single_biu();
        do_reset();
        t_req[1] = 1'b1; t_reg[1] = 4'd8; t_data[1] = 16'h0102; t_size[1] = 1'b1; t_hl[1] = 1'b0;
        drive();
        for (int c = 1; c <= 3; c++) begin
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL single_biu_model c%0d got %h want %h", c, obs(), expv());
            end
            if (c == 1) begin
                vectors++;
                if ({bus.en_write, bus.reg_write, bus.write_data, bus.size, bus.biu_ack}
                    !== {1'b1, 4'd8, 16'h0102, 1'b1, 1'b1}) begin
                    miscompares++;
                    $display("FAIL single_biu_write en=%b reg=%0d data=%h size=%b ack=%b",
                             bus.en_write, bus.reg_write, bus.write_data, bus.size, bus.biu_ack);
                end
            end
            if (c == 2) begin
                vectors++;
                if ({bus.en_write, bus.busy, bus.biu_ack} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL single_biu_after en=%b busy=%b ack=%b want 000",
                             bus.en_write, bus.busy, bus.biu_ack);
                end
            end
            if (bus.biu_ack) t_req[1] = 1'b0;
            drive();
        end
    endtask

    task automatic test_priority();
        int ack_c[3];
        logic [2:0] acks;
        ack_c = '{-1, -1, -1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            t_req[i] = 1'b1; t_reg[i] = 4'(i + 3); t_data[i] = 16'($urandom);
            t_size[i] = 1'($urandom); t_hl[i] = 1'($urandom);
        end
        drive();
        for (int c = 1; c <= 8; c++) begin
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL priority_model c%0d got %h want %h", c, obs(), expv());
            end
            acks = {bus.str_ack, bus.biu_ack, bus.eu_ack};
            for (int i = 0; i < 3; i++) begin
                if (acks[i]) begin
                    if (ack_c[i] < 0) ack_c[i] = c;
                    t_req[i] = 1'b0;
                end
            end
            drive();
        end
        vectors++;
        if (ack_c[0] != 1 || ack_c[1] != 3 || ack_c[2] != 5) begin
            miscompares++;
            $display("FAIL priority_order eu=%0d biu=%0d str=%0d want 1 3 5",
                     ack_c[0], ack_c[1], ack_c[2]);
        end
    endtask

    task automatic test_lock_pair();
        int eu_q[$];
        int biu_c;
        biu_c = -1;
        do_reset();
        t_req[0] = 1'b1; t_reg[0] = 4'd0; t_data[0] = 16'h1234; t_size[0] = 1'b1; t_lock = 1'b1;
        t_req[1] = 1'b1; t_reg[1] = 4'd9; t_data[1] = 16'hbeef; t_size[1] = 1'b1;
        drive();
        for (int c = 1; c <= 7; c++) begin
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL lock_pair_model c%0d got %h want %h", c, obs(), expv());
            end
            if (bus.eu_ack) begin
                eu_q.push_back(c);
                if (eu_q.size() == 1) begin
                    t_reg[0] = 4'd2; t_data[0] = 16'h00ff;
                end else begin
                    t_req[0] = 1'b0; t_lock = 1'b0;
                end
            end
            if (bus.biu_ack) begin
                if (biu_c < 0) biu_c = c;
                t_req[1] = 1'b0;
            end
            drive();
        end
        vectors++;
        if (eu_q.size() != 2 || eu_q[0] != 1 || eu_q[1] != 3 || biu_c != 5) begin
            miscompares++;
            $display("FAIL lock_pair_cycles eu_n=%0d biu=%0d want eu 1,3 biu 5",
                     eu_q.size(), biu_c);
        end
    endtask

    task automatic test_lock_max();
        int eu_q[$];
        int str_c;
        str_c = -1;
        do_reset();
        t_req[0] = 1'b1; t_lock = 1'b1; t_reg[0] = 4'd1; t_data[0] = 16'($urandom);
        t_size[0] = 1'b1;
        t_req[2] = 1'b1; t_reg[2] = 4'd6; t_data[2] = 16'($urandom); t_size[2] = 1'b1;
        drive();
        for (int c = 1; c <= 16; c++) begin
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL lock_max_model c%0d got %h want %h", c, obs(), expv());
            end
            if (bus.eu_ack) begin
                eu_q.push_back(c);
                t_data[0] = 16'($urandom);
                if (eu_q.size() == 6) begin
                    t_req[0] = 1'b0; t_lock = 1'b0;
                end
            end
            if (bus.str_ack) begin
                if (str_c < 0) str_c = c;
                t_req[2] = 1'b0;
            end
            drive();
        end
        vectors++;
        if (eu_q.size() < 5 || eu_q[0] != 1 || eu_q[1] != 3 || eu_q[2] != 5 ||
            eu_q[3] != 7 || eu_q[4] != 11 || str_c != 9) begin
            miscompares++;
            $display("FAIL lock_max_cycles eu_n=%0d str=%0d want eu 1,3,5,7,11 str 9",
                     eu_q.size(), str_c);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        t_req[0] = 1'b1; t_reg[0] = 4'd3; t_data[0] = 16'h5a5a; t_size[0] = 1'b1;
        drive();
        tick();
        vectors++;
        if ({bus.en_write, bus.eu_ack} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_mid_pre en=%b ack=%b want 11", bus.en_write, bus.eu_ack);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.en_write, bus.eu_ack, bus.busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_mid_drop en=%b ack=%b busy=%b want 000",
                     bus.en_write, bus.eu_ack, bus.busy);
        end
        model_reset();
        tick();
        reset = 1'b1;
        tick();
        vectors++;
        if ({bus.en_write, bus.eu_ack, bus.write_data} !== {1'b1, 1'b1, 16'h5a5a}) begin
            miscompares++;
            $display("FAIL rst_mid_regrant en=%b ack=%b data=%h want 1 1 5a5a",
                     bus.en_write, bus.eu_ack, bus.write_data);
        end
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL rst_mid_model got %h want %h", obs(), expv());
        end
        t_req[0] = 1'b0;
        drive();
    endtask

    task automatic test_all_held();
        int order[$];
        int exp_ord[4];
        logic [2:0] acks;
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord = '{0, 1, 2, 0};
`else
        exp_ord = '{0, 0, 0, 0};
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            t_req[i] = 1'b1; t_reg[i] = 4'(i + 10); t_data[i] = 16'($urandom);
            t_size[i] = 1'($urandom); t_hl[i] = 1'($urandom);
        end
        drive();
        for (int c = 1; c <= 8; c++) begin
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL all_held_model c%0d got %h want %h", c, obs(), expv());
            end
            acks = {bus.str_ack, bus.biu_ack, bus.eu_ack};
            for (int i = 0; i < 3; i++) if (acks[i]) order.push_back(i);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (order.size() <= k || order[k] != exp_ord[k]) begin
                miscompares++;
                $display("FAIL all_held_order k%0d got %0d want %0d",
                         k, (order.size() > k) ? order[k] : -1, exp_ord[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] acks;
        do_reset();
        for (int c = 1; c <= 600; c++) begin
            acks = {bus.str_ack, bus.biu_ack, bus.eu_ack};
            for (int i = 0; i < 3; i++) begin
                if (t_req[i] && acks[i]) begin
                    t_req[i] = 1'b0;
                end else if (!t_req[i] && $urandom_range(0, 2) == 0) begin
                    t_req[i]  = 1'b1;
                    t_reg[i]  = 4'($urandom);
                    t_data[i] = 16'($urandom);
                    t_size[i] = 1'($urandom);
                    t_hl[i]   = 1'($urandom);
                end else if (t_req[i] && $urandom_range(0, 15) == 0) begin
                    t_req[i] = 1'b0;
                end
            end
            t_lock = ($urandom_range(0, 3) != 0);
            drive();
            tick();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random_model c%0d got %h want %h", c, obs(), expv());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        test_reset();
        test_single_biu();
        test_priority();
        test_lock_pair();
        test_lock_max();
        test_reset_mid_write();
        test_all_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
